// File: rtl/llki_pkg.sv
// LLKI shared types and constants for the discrete key-load master/slave pair.
// Contents: command opcodes, response status codes, master FSM states, key word width.
package llki_pkg;

    localparam int LLKI_WORD_W = 64;

    typedef enum logic {
        LOAD_KEY  = 1'b0,
        CLEAR_KEY = 1'b1
    } llki_cmd_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_TIMEOUT = 2'd1,
        ST_BAD_LEN = 2'd2
    } llki_status_e;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
        WAITC,
        CLEAR,
        RESP
    } llki_master_state_e;

endpackage

// File: rtl/llki_discrete_master_if.sv
// Bundle of all handshake signals around the LLKI discrete master.
// Groups: command (cmd_*), upstream key words (kw_*), slave side (llki_*), response (rsp_*).
// Modports: master = the llki_discrete_master view, slave = the environment view.
interface llki_discrete_master_if;
    import llki_pkg::*;

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_op;
    logic [4:0]             cmd_len;
    logic                   kw_valid;
    logic                   kw_ready;
    logic [LLKI_WORD_W-1:0] kw_data;
    logic [LLKI_WORD_W-1:0] llki_key_data;
    logic                   llki_key_valid;
    logic                   llki_key_ready;
    logic                   llki_key_complete;
    logic                   llki_clear_key;
    logic                   llki_clear_key_ack;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [1:0]             rsp_status;

    modport master (
        input  cmd_valid, cmd_op, cmd_len, kw_valid, kw_data,
               llki_key_ready, llki_key_complete, llki_clear_key_ack, rsp_ready,
        output cmd_ready, kw_ready, llki_key_data, llki_key_valid,
               llki_clear_key, rsp_valid, rsp_status
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_len, kw_valid, kw_data,
               llki_key_ready, llki_key_complete, llki_clear_key_ack, rsp_ready,
        input  cmd_ready, kw_ready, llki_key_data, llki_key_valid,
               llki_clear_key, rsp_valid, rsp_status
    );

endinterface

// File: rtl/llki_timeout_ctr.sv
// Wait-phase timeout counter.
// Ports: clk, reset_n (sync, active low), clr (zero the count, wins over en),
//        en (count this cycle), tc (count has reached LIMIT-1).
module llki_timeout_ctr #(
    parameter int CNT_W = 16,
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (en)
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign tc = (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/llki_discrete_master.sv
// LLKI discrete key-load master: accepts LOAD_KEY/CLEAR_KEY commands, streams key
// words to the slave one at a time, waits for completion/ack under a timeout and
// returns one status response per command.
// Ports: clk, reset_n (sync, active low), bus (llki_discrete_master_if.master).
module llki_discrete_master #(
    parameter int MAX_WORDS      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          reset_n,
    llki_discrete_master_if.master        bus
);
    import llki_pkg::*;

    llki_master_state_e     state_q, state_d;
    llki_status_e           status_q, status_d;
    logic [4:0]             remaining_q, remaining_d;
    logic [LLKI_WORD_W-1:0] key_data_q, key_data_d;
    logic                   cmd_ready_q, kw_ready_q, key_valid_q, clear_q, rsp_valid_q;
    logic                   tmr_clr, tmr_en, tmr_tc;

    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        remaining_d = remaining_q;
        key_data_d  = key_data_q;
        case (state_q)
            IDLE: begin
                // cmd_ready_q is low on the first cycle out of reset, so gate with it
                if (bus.cmd_valid && cmd_ready_q) begin
                    if (llki_cmd_e'(bus.cmd_op) == CLEAR_KEY) begin
                        state_d = CLEAR;
                    end else if (bus.cmd_len == 5'd0 || int'(bus.cmd_len) > MAX_WORDS) begin
                        status_d = ST_BAD_LEN;
                        state_d  = RESP;
                    end else begin
                        remaining_d = bus.cmd_len;
                        state_d     = FETCH;
                    end
                end
            end
            FETCH: begin
                if (bus.kw_valid && kw_ready_q) begin
                    key_data_d = bus.kw_data;
                    state_d    = SEND;
                end else if (tmr_tc) begin
                    status_d = ST_TIMEOUT;
                    state_d  = RESP;
                end
            end
            SEND: begin
                if (bus.llki_key_ready) begin
                    remaining_d = remaining_q - 5'd1;
                    if (remaining_q == 5'd1) begin
                        // completion seen together with the last word skips WAITC
                        if (bus.llki_key_complete) begin
                            status_d = ST_OK;
                            state_d  = RESP;
                        end else begin
                            state_d = WAITC;
                        end
                    end else begin
                        state_d = FETCH;
                    end
                end else if (tmr_tc) begin
                    status_d = ST_TIMEOUT;
                    state_d  = RESP;
                end
            end
            WAITC: begin
                if (bus.llki_key_complete) begin
                    status_d = ST_OK;
                    state_d  = RESP;
                end else if (tmr_tc) begin
                    status_d = ST_TIMEOUT;
                    state_d  = RESP;
                end
            end
            CLEAR: begin
                if (bus.llki_clear_key_ack) begin
                    status_d = ST_OK;
                    state_d  = RESP;
                end else if (tmr_tc) begin
                    status_d = ST_TIMEOUT;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            status_q    <= ST_OK;
            remaining_q <= '0;
            key_data_q  <= '0;
            cmd_ready_q <= 1'b0;
            kw_ready_q  <= 1'b0;
            key_valid_q <= 1'b0;
            clear_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            remaining_q <= remaining_d;
            key_data_q  <= key_data_d;
            cmd_ready_q <= (state_d == IDLE);
            kw_ready_q  <= (state_d == FETCH);
            key_valid_q <= (state_d == SEND);
            clear_q     <= (state_d == CLEAR);
            rsp_valid_q <= (state_d == RESP);
        end
    end

    // Timer restarts on every state change, including FETCH<->SEND per word.
    assign tmr_clr = (state_d != state_q);
    assign tmr_en  = (state_q inside {FETCH, SEND, WAITC, CLEAR});

    llki_timeout_ctr #(
        .CNT_W (16),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_tmr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .tc      (tmr_tc)
    );

    assign bus.cmd_ready      = cmd_ready_q;
    assign bus.kw_ready       = kw_ready_q;
    assign bus.llki_key_data  = key_data_q;
    assign bus.llki_key_valid = key_valid_q;
    assign bus.llki_clear_key = clear_q;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_status     = status_q;

endmodule

// File: tb/tb_llki_discrete_master.sv
// Directed bench for llki_discrete_master (TIMEOUT_CYCLES=8).
// A negedge process plays the key-word source and the slave ready side and logs
// every word the slave accepts; the main sequence drives commands at posedge+1.
module tb_llki_discrete_master;
    import llki_pkg::*;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    llki_discrete_master_if bus();

    llki_discrete_master #(
        .MAX_WORDS      (16),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- word source / slave model ----------------
    logic [63:0] kw_src[$];
    logic [63:0] got_q[$];
    bit          bfm_flush = 0;
    bit          rdy_hold  = 0;
    int          kw_stall_pct = 0, rdy_stall_pct = 0;
    int          kw_run = 0, rdy_run = 0;
    int          cnt_kwr = 0, cnt_kv = 0;
    int          last_key_cyc = 0;
    logic        p_kwv = 0, p_kwr = 0, p_kv = 0, p_kr = 0, p_rst = 0;
    logic [63:0] p_kwd = '0, p_kd = '0;

    initial begin
        bus.kw_valid       = 1'b0;
        bus.kw_data        = '0;
        bus.llki_key_ready = 1'b0;
        forever begin
            @(negedge clk);
            // p_* hold the values the DUT sampled at the posedge just passed
            if (p_rst && reset_n) begin
                if (p_kv && p_kr) begin
                    got_q.push_back(p_kd);
                    last_key_cyc = cyc;
                end
                if (p_kv && !p_kr) begin
                    chk("hold_vld", bus.llki_key_valid, 1);
                    chk("hold_dat", bus.llki_key_data, p_kd);
                end
                if (p_kwv && p_kwr) begin
                    chk("kw2vld", bus.llki_key_valid, 1);
                    chk("kw2dat", bus.llki_key_data, p_kwd);
                end
            end
            if (bus.kw_ready) cnt_kwr++;
            if (bus.llki_key_valid) cnt_kv++;

            if (bfm_flush) begin
                kw_src.delete();
                bus.kw_valid = 1'b0;
            end else begin
                if (p_kwv && p_kwr) bus.kw_valid = 1'b0;
                if (!bus.kw_valid && kw_src.size() > 0) begin
                    if (kw_run < 3 && $urandom_range(0, 99) < kw_stall_pct) begin
                        kw_run++;
                    end else begin
                        kw_run       = 0;
                        bus.kw_data  = kw_src.pop_front();
                        bus.kw_valid = 1'b1;
                    end
                end
            end

            if (rdy_hold) begin
                bus.llki_key_ready = 1'b0;
            end else if (rdy_run < 3 && $urandom_range(0, 99) < rdy_stall_pct) begin
                bus.llki_key_ready = 1'b0;
                rdy_run++;
            end else begin
                bus.llki_key_ready = 1'b1;
                rdy_run = 0;
            end

            p_kwv = bus.kw_valid;       p_kwr = bus.kw_ready;   p_kwd = bus.kw_data;
            p_kv  = bus.llki_key_valid; p_kr  = bus.llki_key_ready;
            p_kd  = bus.llki_key_data;  p_rst = reset_n;
        end
    end

    // ---------------- sequence helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic op, input logic [4:0] len, output int acc_cyc);
        bit done = 0;
        bus.cmd_op    = op;
        bus.cmd_len   = len;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (bus.cmd_ready) done = 1;
            tick();
        end
        bus.cmd_valid = 1'b0;
        acc_cyc = cyc;
        chk("cmd_accept", done, 1);
    endtask

    task automatic wait_words(input string tag, input int n);
        for (int i = 0; i < 200 && got_q.size() < n; i++) tick();
        chk(tag, got_q.size(), n);
    endtask

    task automatic wait_rsp(input string tag, input logic [1:0] exp, output int rsp_cyc);
        bit seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (bus.rsp_valid) seen = 1;
            else tick();
        end
        rsp_cyc = cyc;
        chk({tag, "_seen"}, seen, 1);
        if (seen) begin
            chk({tag, "_status"}, bus.rsp_status, exp);
            chk({tag, "_crdy_lo"}, bus.cmd_ready, 0);
            bus.rsp_ready = 1'b1;
            tick();
            bus.rsp_ready = 1'b0;
            chk({tag, "_rsp_drop"}, bus.rsp_valid, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int acc, rc, kwr0, kv0;
        logic [4:0] bad_lens [2];
        bad_lens[0] = 5'd0;
        bad_lens[1] = 5'd17;

        bus.cmd_valid          = 1'b0;
        bus.cmd_op             = 1'b0;
        bus.cmd_len            = '0;
        bus.llki_key_complete  = 1'b0;
        bus.llki_clear_key_ack = 1'b0;
        bus.rsp_ready          = 1'b0;

        // reset state
        reset_n = 1'b0;
        repeat (3) tick();
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_kw_ready",  bus.kw_ready, 0);
        chk("rst_key_valid", bus.llki_key_valid, 0);
        chk("rst_key_data",  bus.llki_key_data, 0);
        chk("rst_clear",     bus.llki_clear_key, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_status",    bus.rsp_status, 0);
        reset_n = 1'b1;
        tick();
        chk("idle_cmd_ready", bus.cmd_ready, 1);

        // LOAD len=2, slave ready at once, complete 3 cycles after the last word
        got_q.delete();
        kw_src.push_back(64'h0123_4567_89AB_CDEF);
        kw_src.push_back(64'hFEDC_BA98_7654_3210);
        send_cmd(LOAD_KEY, 5'd2, acc);
        wait_words("load2_words", 2);
        if (got_q.size() == 2) begin
            chk("load2_w0", got_q[0], 64'h0123_4567_89AB_CDEF);
            chk("load2_w1", got_q[1], 64'hFEDC_BA98_7654_3210);
        end
        repeat (3) tick();
        bus.llki_key_complete = 1'b1;
        wait_rsp("load2", 2'd0, rc);
        bus.llki_key_complete = 1'b0;

        // CLEAR, ack after 5 cycles of llki_clear_key
        send_cmd(CLEAR_KEY, 5'd0, acc);
        for (int i = 0; i < 5; i++) begin
            chk("clr_high", bus.llki_clear_key, 1);
            if (i == 4) bus.llki_clear_key_ack = 1'b1;
            tick();
        end
        chk("clr_drop", bus.llki_clear_key, 0);
        chk("clr_rsp_lat", bus.rsp_valid, 1);
        bus.llki_clear_key_ack = 1'b0;
        wait_rsp("clear", 2'd0, rc);

        // bad lengths: no word traffic at all
        foreach (bad_lens[k]) begin
            kwr0 = cnt_kwr;
            kv0  = cnt_kv;
            send_cmd(LOAD_KEY, bad_lens[k], acc);
            wait_rsp("badlen", 2'd2, rc);
            tick();
            chk("badlen_no_kwr", cnt_kwr - kwr0, 0);
            chk("badlen_no_kv",  cnt_kv - kv0, 0);
        end

        // LOAD len=2, complete never comes -> timeout after 8 WAITC cycles
        got_q.delete();
        kw_src.push_back(64'h1111_2222_3333_4444);
        kw_src.push_back(64'h5555_6666_7777_8888);
        send_cmd(LOAD_KEY, 5'd2, acc);
        wait_words("tmo_words", 2);
        wait_rsp("tmo", 2'd1, rc);
        chk("tmo_waitc_cycles", rc - last_key_cyc, 8);
        chk("tmo_key_valid", bus.llki_key_valid, 0);

        // len=16 with random stalls; complete held high throughout (stray until the end)
        got_q.delete();
        for (int i = 0; i < 16; i++) kw_src.push_back(64'(i));
        kw_stall_pct  = 40;
        rdy_stall_pct = 40;
        bus.llki_key_complete = 1'b1;
        send_cmd(LOAD_KEY, 5'd16, acc);
        wait_rsp("len16", 2'd0, rc);
        bus.llki_key_complete = 1'b0;
        kw_stall_pct  = 0;
        rdy_stall_pct = 0;
        chk("len16_count", got_q.size(), 16);
        for (int i = 0; i < 16 && i < got_q.size(); i++)
            chk("len16_word", got_q[i], 64'(i));

        // reset while in SEND
        got_q.delete();
        rdy_hold = 1;
        kw_src.push_back(64'hDEAD_BEEF_0000_0001);
        send_cmd(LOAD_KEY, 5'd2, acc);
        for (int i = 0; i < 20 && !bus.llki_key_valid; i++) tick();
        chk("rst_send_reached", bus.llki_key_valid, 1);
        reset_n = 1'b0;
        tick();
        chk("rst_send_key_valid", bus.llki_key_valid, 0);
        chk("rst_send_rsp_valid", bus.rsp_valid, 0);
        chk("rst_send_cmd_ready", bus.cmd_ready, 0);
        chk("rst_send_key_data",  bus.llki_key_data, 0);
        bfm_flush = 1;
        repeat (2) tick();
        bfm_flush = 0;
        rdy_hold  = 0;
        reset_n   = 1'b1;
        tick();
        got_q.delete();
        kw_src.push_back(64'hA5A5_5A5A_C3C3_3C3C);
        send_cmd(LOAD_KEY, 5'd1, acc);
        wait_words("post_rst_words", 1);
        if (got_q.size() == 1) chk("post_rst_w0", got_q[0], 64'hA5A5_5A5A_C3C3_3C3C);
        bus.llki_key_complete = 1'b1;
        wait_rsp("post_rst", 2'd0, rc);
        bus.llki_key_complete = 1'b0;

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
